// File: rtl/bus_bridge_req_arbiter.sv
// bus_bridge_pkg and bus_bridge_req_arbiter: round-robin sharing of one
// bridge request/response channel between NUM_REQ upstream requesters, with an
// in-order tracking FIFO that steers each response back to its issuer.
// Optional feature macro: BUS_BRIDGE_ARB_TIMEOUT_EN (response watchdog).
package bus_bridge_pkg;
    typedef struct packed {
        logic        is_write;
        logic [15:0] addr;
        logic [7:0]  write_data;
    } bus_bridge_req_t;

    typedef struct packed {
        logic       is_write;
        logic [7:0] read_data;
    } bus_bridge_resp_t;
endpackage

module bus_bridge_req_arbiter
    import bus_bridge_pkg::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic             [NUM_REQ-1:0]    up_req_valid,
    output logic             [NUM_REQ-1:0]    up_req_ready,
    input  bus_bridge_req_t  [NUM_REQ-1:0]    up_req_payload,
    output logic             [NUM_REQ-1:0]    up_resp_valid,
    input  logic             [NUM_REQ-1:0]    up_resp_ready,
    output bus_bridge_resp_t                  up_resp_payload,
    output logic                              dn_req_valid,
    input  logic                              dn_req_ready,
    output bus_bridge_req_t                   dn_req_payload,
    input  logic                              dn_resp_valid,
    output logic                              dn_resp_ready,
    input  bus_bridge_resp_t                  dn_resp_payload,
    output logic             [3:0]            outstanding,
    output logic                              stray_resp,
    output logic                              timeout_err
);
    localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 4 || MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 8 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
        $error("bus_bridge_req_arbiter: parameter out of legal range");
    end

    // Circular pointer advance that wraps at the FIFO depth.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(MAX_OUTSTANDING - 1)) begin
            ptr_inc = '0;
        end else begin
            ptr_inc = p + 1'b1;
        end
    endfunction

    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                  dn_req_valid_q;
    bus_bridge_req_t       dn_req_payload_q;
    logic [IDX_W-1:0]      idx_mem_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [3:0]            cnt_q, cnt_d;
    logic                  stray_q, timeout_err_q;

    logic [IDX_W-1:0]      winner_s, head_idx_s;
    logic                  found_s, take_s, accept_s, pop_s, forced_s;
    logic                  fifo_empty_s, fifo_full_s, slot_free_s, wd_expired_s;
    int                    cand_s;

    assign head_idx_s   = idx_mem_q[rd_ptr_q];
    assign fifo_empty_s = (cnt_q == 4'd0);
    assign fifo_full_s  = (cnt_q == 4'(MAX_OUTSTANDING));
    assign slot_free_s  = !dn_req_valid_q || dn_req_ready;
    assign cnt_d        = cnt_q + {3'b000, accept_s} - {3'b000, pop_s};

`ifdef BUS_BRIDGE_ARB_TIMEOUT_EN
    logic                  wr_mem_q [MAX_OUTSTANDING];
    logic                  head_wr_s;
    logic [7:0]            wd_q;

    assign head_wr_s    = wr_mem_q[rd_ptr_q];
    assign wd_expired_s = (wd_q >= 8'(TIMEOUT_CYCLES));

    // Watchdog: counts stalled cycles on a non-empty FIFO, clears on any pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= 8'd0;
        end else if (fifo_empty_s || pop_s || (wd_expired_s && dn_resp_valid)) begin
            wd_q <= 8'd0;
        end else if (!wd_expired_s) begin
            wd_q <= wd_q + 8'd1;
        end else begin
            wd_q <= wd_q;
        end
    end

    // Remembers is_write per tracked entry so a forced response can echo it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_mem_q <= '{default: 1'b0};
        end else if (accept_s) begin
            wr_mem_q[wr_ptr_q] <= up_req_payload[winner_s].is_write;
        end else begin
            wr_mem_q <= wr_mem_q;
        end
    end
`else
    assign wd_expired_s = 1'b0;
`endif

    // Response steering: route to the FIFO head, drain strays when empty.
    always_comb begin
        up_resp_valid   = '0;
        up_resp_payload = dn_resp_payload;
        dn_resp_ready   = 1'b1;
        forced_s        = 1'b0;
        pop_s           = 1'b0;
        if (fifo_empty_s) begin
            dn_resp_ready = 1'b1;
        end else begin
            dn_resp_ready = up_resp_ready[head_idx_s];
            if (dn_resp_valid) begin
                up_resp_valid[head_idx_s] = 1'b1;
            end else if (wd_expired_s) begin
                up_resp_valid[head_idx_s] = 1'b1;
                forced_s                  = 1'b1;
`ifdef BUS_BRIDGE_ARB_TIMEOUT_EN
                up_resp_payload           = {head_wr_s, 8'h00};
`endif
            end else begin
                forced_s = 1'b0;
            end
            pop_s = up_resp_valid[head_idx_s] && up_resp_ready[head_idx_s];
        end
    end

    // Round-robin search from rr_ptr and the single upstream ready.
    always_comb begin
        winner_s     = rr_ptr_q;
        found_s      = 1'b0;
        take_s       = 1'b0;
        cand_s       = 0;
        up_req_ready = '0;
        accept_s     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s   = (int'(rr_ptr_q) + k) % NUM_REQ;
            take_s   = !found_s && up_req_valid[cand_s];
            winner_s = take_s ? IDX_W'(cand_s) : winner_s;
            found_s  = found_s | take_s;
        end
        // A full FIFO still accepts when its head pops in the same cycle.
        if (found_s && slot_free_s && (!fifo_full_s || pop_s)) begin
            up_req_ready[winner_s] = 1'b1;
            accept_s               = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        rr_ptr_d = (winner_s == IDX_W'(NUM_REQ - 1)) ? '0 : winner_s + 1'b1;
    end

    // Round-robin pointer and the registered downstream request slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q         <= '0;
            dn_req_valid_q   <= 1'b0;
            dn_req_payload_q <= '0;
        end else if (accept_s) begin
            rr_ptr_q         <= rr_ptr_d;
            dn_req_valid_q   <= 1'b1;
            dn_req_payload_q <= up_req_payload[winner_s];
        end else if (dn_req_ready) begin
            dn_req_valid_q   <= 1'b0;
        end else begin
            dn_req_valid_q   <= dn_req_valid_q;
        end
    end

    // Tracking FIFO: requester index pushed at upstream accept, popped per response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_mem_q <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= 4'd0;
        end else begin
            if (accept_s) begin
                idx_mem_q[wr_ptr_q] <= winner_s;
                wr_ptr_q            <= ptr_inc(wr_ptr_q);
            end else begin
                wr_ptr_q            <= wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end else begin
                rd_ptr_q <= rd_ptr_q;
            end
            cnt_q <= cnt_d;
        end
    end

    // One-cycle status pulses for stray and forced (timed-out) responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stray_q       <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            stray_q       <= dn_resp_valid && fifo_empty_s;
            timeout_err_q <= forced_s && pop_s;
        end
    end

    assign dn_req_valid   = dn_req_valid_q;
    assign dn_req_payload = dn_req_payload_q;
    assign outstanding    = cnt_q;
    assign stray_resp     = stray_q;
    assign timeout_err    = timeout_err_q;
endmodule

// File: tb/tb_bus_bridge_req_arbiter.sv
// Self-checking bench for bus_bridge_req_arbiter (NUM_REQ=2, depth 4, timeout 10).
module tb_bus_bridge_req_arbiter;
    import bus_bridge_pkg::*;

`ifdef BUS_BRIDGE_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int TO_LIM = 10;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [1:0]                up_req_valid = 2'b00;
    logic [1:0]                up_req_ready;
    bus_bridge_req_t [1:0]     up_req_payload = '0;
    logic [1:0]                up_resp_valid;
    logic [1:0]                up_resp_ready = 2'b00;
    bus_bridge_resp_t          up_resp_payload;
    logic                      dn_req_valid;
    logic                      dn_req_ready = 1'b0;
    bus_bridge_req_t           dn_req_payload;
    logic                      dn_resp_valid = 1'b0;
    logic                      dn_resp_ready;
    bus_bridge_resp_t          dn_resp_payload = '0;
    logic [3:0]                outstanding;
    logic                      stray_resp;
    logic                      timeout_err;

    int checks = 0;
    int errors = 0;

    bus_bridge_req_arbiter #(.NUM_REQ(2), .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(TO_LIM)) dut (
        .clk(clk), .rst_n(rst_n),
        .up_req_valid(up_req_valid), .up_req_ready(up_req_ready), .up_req_payload(up_req_payload),
        .up_resp_valid(up_resp_valid), .up_resp_ready(up_resp_ready), .up_resp_payload(up_resp_payload),
        .dn_req_valid(dn_req_valid), .dn_req_ready(dn_req_ready), .dn_req_payload(dn_req_payload),
        .dn_resp_valid(dn_resp_valid), .dn_resp_ready(dn_resp_ready), .dn_resp_payload(dn_resp_payload),
        .outstanding(outstanding), .stray_resp(stray_resp), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        up_req_valid = 2'b00; up_resp_ready = 2'b00; dn_req_ready = 1'b0;
        dn_resp_valid = 1'b0; up_req_payload = '0; dn_resp_payload = '0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0; idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        up_req_valid = 2'b01; up_req_payload[0] = '{is_write: 1'b1, addr: 16'hBEEF, write_data: 8'h77};
        @(negedge clk);
        rst_n = 1'b0; up_req_valid = 2'b00; #1;
        checks++; if (up_req_ready !== 2'b00) begin errors++; $display("FAIL rst_up_req_ready got %b want 00", up_req_ready); end
        checks++; if (dn_req_valid !== 1'b0) begin errors++; $display("FAIL rst_dn_req_valid got %b want 0", dn_req_valid); end
        checks++; if (dn_req_payload !== 25'd0) begin errors++; $display("FAIL rst_dn_req_payload got %h want 0", dn_req_payload); end
        checks++; if (up_resp_valid !== 2'b00) begin errors++; $display("FAIL rst_up_resp_valid got %b want 00", up_resp_valid); end
        checks++; if (dn_resp_ready !== 1'b1) begin errors++; $display("FAIL rst_dn_resp_ready got %b want 1", dn_resp_ready); end
        checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL rst_outstanding got %0d want 0", outstanding); end
        checks++; if (stray_resp !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL rst_pulses got %b%b want 00", stray_resp, timeout_err); end
        @(negedge clk);
        rst_n = 1'b1; dn_resp_valid = 1'b1; up_resp_ready = 2'b01; #1;
        checks++; if (up_resp_valid !== 2'b00) begin errors++; $display("FAIL post_rst_resp_routed got %b want 00", up_resp_valid); end
        @(posedge clk); #1;
        checks++; if (stray_resp !== 1'b1) begin errors++; $display("FAIL post_rst_stray got %b want 1", stray_resp); end
        @(negedge clk); dn_resp_valid = 1'b0;
    endtask

    task automatic test_basic_read();
        do_reset();
        @(negedge clk);
        up_req_valid = 2'b01; dn_req_ready = 1'b1;
        up_req_payload[0] = '{is_write: 1'b0, addr: 16'h0123, write_data: 8'h00}; #1;
        checks++; if (up_req_ready !== 2'b01) begin errors++; $display("FAIL basic_ready got %b want 01", up_req_ready); end
        checks++; if (dn_req_valid !== 1'b0) begin errors++; $display("FAIL basic_latency got %b want 0", dn_req_valid); end
        @(posedge clk); #1;
        checks++; if (dn_req_valid !== 1'b1 || dn_req_payload.addr !== 16'h0123) begin errors++; $display("FAIL basic_dn_req got v=%b addr=%h want v=1 addr=0123", dn_req_valid, dn_req_payload.addr); end
        checks++; if (outstanding !== 4'd1) begin errors++; $display("FAIL basic_outstanding got %0d want 1", outstanding); end
        @(negedge clk);
        up_req_valid = 2'b00; dn_resp_valid = 1'b1; dn_resp_payload = '{is_write: 1'b0, read_data: 8'h5A}; up_resp_ready = 2'b01; #1;
        checks++; if (up_resp_valid !== 2'b01 || up_resp_payload.read_data !== 8'h5A) begin errors++; $display("FAIL basic_resp got v=%b d=%h want v=01 d=5a", up_resp_valid, up_resp_payload.read_data); end
        checks++; if (dn_resp_ready !== 1'b1) begin errors++; $display("FAIL basic_dn_resp_ready got %b want 1", dn_resp_ready); end
        @(posedge clk); #1;
        checks++; if (outstanding !== 4'd0 || dn_req_valid !== 1'b0) begin errors++; $display("FAIL basic_done got out=%0d v=%b want 0 0", outstanding, dn_req_valid); end
        @(negedge clk); dn_resp_valid = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_rdy [4];
        logic [15:0] exp_addr [4];
        exp_rdy  = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_addr = '{16'h1000, 16'h2000, 16'h1000, 16'h2000};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            up_req_valid = 2'b11; dn_req_ready = 1'b1;
            up_req_payload[0] = '{is_write: 1'b0, addr: 16'h1000, write_data: 8'h00};
            up_req_payload[1] = '{is_write: 1'b0, addr: 16'h2000, write_data: 8'h00}; #1;
            checks++; if (up_req_ready !== exp_rdy[i]) begin errors++; $display("FAIL rr_grant%0d got %b want %b", i, up_req_ready, exp_rdy[i]); end
            @(posedge clk); #1;
            checks++; if (dn_req_payload.addr !== exp_addr[i]) begin errors++; $display("FAIL rr_addr%0d got %h want %h", i, dn_req_payload.addr, exp_addr[i]); end
        end
        @(negedge clk); up_req_valid = 2'b00;
    endtask

    task automatic test_backpressure();
        bus_bridge_req_t pa, pb;
        pa = '{is_write: 1'b1, addr: 16'hAAAA, write_data: 8'hA5};
        pb = '{is_write: 1'b0, addr: 16'hBBBB, write_data: 8'h00};
        do_reset();
        @(negedge clk);
        up_req_valid = 2'b01; up_req_payload[0] = pa; dn_req_ready = 1'b0;
        @(negedge clk);
        up_req_valid = 2'b10; up_req_payload[1] = pb;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (up_req_ready !== 2'b00) begin errors++; $display("FAIL bp_ready%0d got %b want 00", i, up_req_ready); end
            @(posedge clk); #1;
            checks++; if (dn_req_valid !== 1'b1 || dn_req_payload !== pa) begin errors++; $display("FAIL bp_hold%0d got v=%b p=%h want v=1 p=%h", i, dn_req_valid, dn_req_payload, pa); end
            @(negedge clk);
        end
        dn_req_ready = 1'b1; #1;
        checks++; if (up_req_ready !== 2'b10) begin errors++; $display("FAIL bp_release_ready got %b want 10", up_req_ready); end
        @(posedge clk); #1;
        checks++; if (dn_req_valid !== 1'b1 || dn_req_payload !== pb) begin errors++; $display("FAIL bp_b2b got v=%b p=%h want v=1 p=%h", dn_req_valid, dn_req_payload, pb); end
        @(negedge clk); up_req_valid = 2'b00;
    endtask

    task automatic test_fill();
        logic [1:0] exp_route [4];
        logic [7:0] d;
        exp_route = '{2'b01, 2'b10, 2'b01, 2'b10};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            d = 8'h11 * 8'(i + 1);
            up_req_valid = 2'b11; dn_req_ready = 1'b1;
            up_req_payload[0] = '{is_write: 1'b1, addr: 16'h0040, write_data: d};
            up_req_payload[1] = '{is_write: 1'b1, addr: 16'h0080, write_data: d};
            @(posedge clk); #1;
            checks++; if (dn_req_payload.write_data !== d || dn_req_payload.is_write !== 1'b1) begin errors++; $display("FAIL fill_wdata%0d got %h want %h", i, dn_req_payload.write_data, d); end
        end
        @(negedge clk); #1;
        checks++; if (outstanding !== 4'd4) begin errors++; $display("FAIL fill_outstanding got %0d want 4", outstanding); end
        checks++; if (up_req_ready !== 2'b00) begin errors++; $display("FAIL fill_full_ready got %b want 00", up_req_ready); end
        up_req_valid = 2'b00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            dn_resp_valid = 1'b1; up_resp_ready = 2'b11; dn_resp_payload = '{is_write: 1'b1, read_data: 8'h00}; #1;
            checks++; if (up_resp_valid !== exp_route[i]) begin errors++; $display("FAIL fill_route%0d got %b want %b", i, up_resp_valid, exp_route[i]); end
        end
        @(negedge clk); dn_resp_valid = 1'b0; #1;
        checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL fill_drained got %0d want 0", outstanding); end
    endtask

    task automatic test_stray();
        do_reset();
        @(negedge clk);
        dn_resp_valid = 1'b1; up_resp_ready = 2'b11; #1;
        checks++; if (dn_resp_ready !== 1'b1 || up_resp_valid !== 2'b00) begin errors++; $display("FAIL stray_drain got rdy=%b v=%b want 1 00", dn_resp_ready, up_resp_valid); end
        checks++; if (stray_resp !== 1'b0) begin errors++; $display("FAIL stray_early got %b want 0", stray_resp); end
        @(posedge clk); #1;
        checks++; if (stray_resp !== 1'b1) begin errors++; $display("FAIL stray_pulse got %b want 1", stray_resp); end
        @(negedge clk); dn_resp_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (stray_resp !== 1'b0) begin errors++; $display("FAIL stray_one_cycle got %b want 0", stray_resp); end
    endtask

`ifdef BUS_BRIDGE_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit found;
        found = 1'b0;
        do_reset();
        @(negedge clk);
        up_req_valid = 2'b01; dn_req_ready = 1'b1;
        up_req_payload[0] = '{is_write: 1'b0, addr: 16'h0300, write_data: 8'h00};
        @(negedge clk);
        up_req_valid = 2'b00; up_resp_ready = 2'b01; dn_resp_payload = '{is_write: 1'b1, read_data: 8'hFF};
        for (int i = 0; i < 40; i++) begin
            #1;
            if (up_resp_valid == 2'b01) begin found = 1'b1; break; end
            checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_early_err at %0d got %b want 0", i, timeout_err); end
            @(negedge clk);
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL to_forced_resp got none want 01 within 40 cycles"); end
        checks++; if (up_resp_payload !== 9'h000) begin errors++; $display("FAIL to_payload got %h want 000", up_resp_payload); end
        @(posedge clk); #1;
        checks++; if (timeout_err !== 1'b1 || outstanding !== 4'd0) begin errors++; $display("FAIL to_pulse got err=%b out=%0d want 1 0", timeout_err, outstanding); end
        @(posedge clk); #1;
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_one_pulse got %b want 0", timeout_err); end
    endtask
`endif

    task automatic test_random();
        int m_rr, m_wd, winner, head, idx;
        int mq_idx [$];
        bit mq_w [$];
        bit m_dv, m_stray, m_to, e_pop, e_forced, e_acc, expired;
        bus_bridge_req_t m_dp;
        bus_bridge_resp_t e_rpay;
        logic [1:0] e_rv, e_qr;
        logic e_drdy;
        logic [31:0] r;
        m_rr = 0; m_wd = 0; m_dv = 1'b0; m_dp = '0; m_stray = 1'b0; m_to = 1'b0;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            up_req_valid = 2'($urandom);
            r = $urandom; up_req_payload[0] = r[24:0];
            r = $urandom; up_req_payload[1] = r[24:0];
            dn_req_ready = 1'($urandom_range(0, 3) != 0);
            dn_resp_valid = 1'($urandom_range(0, 2) == 0);
            r = $urandom; dn_resp_payload = r[8:0];
            up_resp_ready = 2'($urandom_range(0, 3) | 32'($urandom_range(0, 1) * 3));
            #1;
            e_rv = 2'b00; e_pop = 1'b0; e_forced = 1'b0; e_rpay = dn_resp_payload; e_drdy = 1'b1;
            expired = TO_EN && (m_wd >= TO_LIM);
            if (mq_idx.size() != 0) begin
                head = mq_idx[0];
                e_drdy = up_resp_ready[head];
                if (dn_resp_valid) e_rv[head] = 1'b1;
                else if (expired) begin e_rv[head] = 1'b1; e_forced = 1'b1; e_rpay = {mq_w[0], 8'h00}; end
                e_pop = e_rv[head] && up_resp_ready[head];
            end
            winner = -1;
            for (int k = 0; k < 2; k++) begin
                idx = (m_rr + k) % 2;
                if (winner < 0 && up_req_valid[idx]) winner = idx;
            end
            e_qr = 2'b00;
            e_acc = (winner >= 0) && (!m_dv || dn_req_ready) && (mq_idx.size() < 4 || e_pop);
            if (e_acc) e_qr[winner] = 1'b1;
            checks++; if (up_req_ready !== e_qr) begin errors++; $display("FAIL rnd_up_req_ready cyc %0d got %b want %b", cyc, up_req_ready, e_qr); end
            checks++; if (up_resp_valid !== e_rv) begin errors++; $display("FAIL rnd_up_resp_valid cyc %0d got %b want %b", cyc, up_resp_valid, e_rv); end
            checks++; if (dn_resp_ready !== e_drdy) begin errors++; $display("FAIL rnd_dn_resp_ready cyc %0d got %b want %b", cyc, dn_resp_ready, e_drdy); end
            if (e_rv != 2'b00) begin
                checks++; if (up_resp_payload !== e_rpay) begin errors++; $display("FAIL rnd_resp_payload cyc %0d got %h want %h", cyc, up_resp_payload, e_rpay); end
            end
            @(posedge clk);
            m_stray = dn_resp_valid && (mq_idx.size() == 0);
            m_to = e_forced && e_pop;
            if (mq_idx.size() == 0 || e_pop || (expired && dn_resp_valid)) m_wd = 0;
            else if (!expired) m_wd++;
            if (e_pop) begin void'(mq_idx.pop_front()); void'(mq_w.pop_front()); end
            if (e_acc) begin
                mq_idx.push_back(winner); mq_w.push_back(up_req_payload[winner].is_write);
                m_dv = 1'b1; m_dp = up_req_payload[winner]; m_rr = (winner + 1) % 2;
            end else if (dn_req_ready) m_dv = 1'b0;
            #1;
            checks++; if (dn_req_valid !== m_dv || dn_req_payload !== m_dp) begin errors++; $display("FAIL rnd_dn_req cyc %0d got v=%b p=%h want v=%b p=%h", cyc, dn_req_valid, dn_req_payload, m_dv, m_dp); end
            checks++; if (outstanding !== 4'(mq_idx.size())) begin errors++; $display("FAIL rnd_outstanding cyc %0d got %0d want %0d", cyc, outstanding, mq_idx.size()); end
            checks++; if (stray_resp !== m_stray || timeout_err !== m_to) begin errors++; $display("FAIL rnd_pulses cyc %0d got %b%b want %b%b", cyc, stray_resp, timeout_err, m_stray, m_to); end
        end
        @(negedge clk); idle_inputs();
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_round_robin();
        test_backpressure();
        test_fill();
        test_stray();
`ifdef BUS_BRIDGE_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
